// File: rtl/fir_pcpi_accel_param.sv
// PCPI FIR co-processor: addressed signed coefficient bank, circular control-bit history
// and a LANES-wide MAC engine producing one saturated estimator output per CALC.
module fir_pcpi_accel_param #(
    parameter int unsigned N                 = 8,
    parameter int unsigned K                 = 128,
    parameter int unsigned OSR               = 7,
    parameter int unsigned WIDTH_COEFFICIENT = 32,
    parameter int unsigned LANES             = 16,
    parameter int unsigned ACC_WIDTH         = WIDTH_COEFFICIENT + $clog2(K * N) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int unsigned AW         = $clog2(K);
    localparam int unsigned NW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GROUPS     = K / LANES;
    localparam int unsigned GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned M          = 32 / N;
    localparam int unsigned SAT_W      = (ACC_WIDTH > 32) ? ACC_WIDTH : 33;
    localparam int unsigned unused_osr = OSR;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RUN, S_DONE} state_e;

    state_e                              state_q;
    logic [GW-1:0]                       cnt_q;
    logic                                cool_q;
    logic signed [ACC_WIDTH-1:0]         acc_q;
    logic signed [ACC_WIDTH-1:0]         acc_d;
    logic                                ready_q;
    logic                                wr_q;
    logic                                wait_q;
    logic [31:0]                         rd_q;

    logic [N-1:0]                        hist_q [K];
    logic signed [WIDTH_COEFFICIENT-1:0] coef_q [K][N];
    logic [AW-1:0]                       wp_q;

    logic [2:0]                          funct3;
    logic                                accept;
    logic                                op_calc;
    logic                                op_loadh;
    logic                                op_loads;
    logic                                op_clrs;
    logic                                lh_ok;
    logic [AW-1:0]                       lh_tap;
    logic [NW-1:0]                       lh_state;
    logic [31:0]                         c_val;
    logic [31:0]                         push_cnt;
    logic unused_bits;

    assign funct3   = pcpi_insn[14:12];
    // A one-cycle cool-down after every acknowledge keeps a still-held valid from re-issuing.
    assign accept   = (state_q == S_IDLE) && !cool_q && pcpi_valid &&
                      ((pcpi_insn & 32'hfe00_707f) == {17'd0, funct3, 12'h027});
    assign op_calc  = accept && (funct3 == 3'd2);
    assign op_loadh = accept && (funct3 == 3'd3);
    assign op_loads = accept && (funct3 == 3'd4);
    assign op_clrs  = accept && (funct3 == 3'd5);

    assign lh_ok    = (32'(pcpi_rs2[25:16]) < K) && (32'(pcpi_rs2[3:0]) < N);
    assign lh_tap   = pcpi_rs2[16 +: AW];
    assign lh_state = pcpi_rs2[NW-1:0];
    assign c_val    = 32'(pcpi_rs2[4:0]);
    assign push_cnt = (c_val < M) ? c_val : M;

    assign unused_bits = ^{pcpi_insn, pcpi_rs1, pcpi_rs2};

    // Storage only changes on the edge that accepts a store op, so it is frozen during RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned t = 0; t < K; t++) begin
                hist_q[t] <= '0;
                for (int unsigned n = 0; n < N; n++) begin
                    coef_q[t][n] <= '0;
                end
            end
            wp_q <= '0;
        end else if (op_loadh) begin
            if (lh_ok) begin
                coef_q[lh_tap][lh_state] <= pcpi_rs1[WIDTH_COEFFICIENT-1:0];
            end
        end else if (op_loads) begin
            for (int unsigned j = 0; j < M; j++) begin
                if (j < push_cnt) begin
                    hist_q[wp_q + AW'(j)] <= pcpi_rs1[j*N +: N];
                end
            end
            wp_q <= wp_q + AW'(push_cnt);
        end else if (op_clrs) begin
            for (int unsigned t = 0; t < K; t++) begin
                hist_q[t] <= '0;
            end
            wp_q <= '0;
        end
    end

    logic signed [ACC_WIDTH-1:0] group_sum;
    logic [AW-1:0]               tap_v;
    logic [AW-1:0]               idx_v;

    // Tap t lives at hist[wp-1-t]; modular AW-bit arithmetic performs the wrap.
    always_comb begin
        group_sum = '0;
        tap_v     = '0;
        idx_v     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            tap_v = AW'(32'(cnt_q) * LANES + l);
            idx_v = wp_q - AW'(1) - tap_v;
            for (int unsigned n = 0; n < N; n++) begin
                if (hist_q[idx_v][n]) begin
                    group_sum = group_sum + ACC_WIDTH'(coef_q[tap_v][n]);
                end else begin
                    group_sum = group_sum - ACC_WIDTH'(coef_q[tap_v][n]);
                end
            end
        end
    end

    logic signed [SAT_W-1:0] acc_x;
    logic [31:0]             sat_val;

    assign acc_d = acc_q + group_sum;
    assign acc_x = SAT_W'(acc_d);

    always_comb begin
        if (!acc_x[SAT_W-1] && (|acc_x[SAT_W-2:31])) begin
            sat_val = 32'h7fff_ffff;
        end else if (acc_x[SAT_W-1] && !(&acc_x[SAT_W-2:31])) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = acc_x[31:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            cool_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            wait_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rd_q   <= '0;
                    cool_q <= 1'b0;
                    if (op_calc) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        wait_q  <= 1'b1;
                    end else if (op_loadh || op_loads || op_clrs) begin
                        state_q <= S_ACK;
                        ready_q <= 1'b1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    cool_q  <= 1'b1;
                end
                S_RUN: begin
                    if (!pcpi_valid) begin
                        state_q <= S_IDLE;
                        wait_q  <= 1'b0;
                    end else if (cnt_q == GW'(GROUPS - 1)) begin
                        state_q <= S_DONE;
                        wait_q  <= 1'b0;
                        ready_q <= 1'b1;
                        wr_q    <= 1'b1;
                        rd_q    <= sat_val;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + GW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    rd_q    <= '0;
                    cool_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pcpi_ready = ready_q;
    assign pcpi_wr    = wr_q;
    assign pcpi_rd    = rd_q;
    assign pcpi_wait  = wait_q;

endmodule
